// File: rtl/zxuno_regbus_arbiter.sv
// Register-bus arbiter: the Z80 port decoder always owns the bus; one auxiliary master runs in CPU-idle gaps.
// Optional give-up-after-N-aborts behaviour is enabled with the REGARB_RETRY_LIMIT_EN macro.
module zxuno_regbus_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int IDLE_GUARD    = 4,
    parameter int MAX_RETRIES   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_din,
    input  logic       cpu_write,
    input  logic       cpu_read,
    input  logic       cpu_regaddr_changed,
    input  logic       aux_req,
    input  logic       aux_we,
    input  logic [7:0] aux_addr,
    input  logic [7:0] aux_wdata,
    output logic       aux_ack,
    output logic       aux_err,
    output logic [7:0] aux_rdata,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_write,
    output logic       reg_read,
    output logic       reg_regaddr_changed,
    input  logic [7:0] reg_rdata
);
    localparam int GW = $clog2(IDLE_GUARD + 1);
    localparam int AW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [GW-1:0] GUARD_MAX = GW'(IDLE_GUARD);
    localparam logic [AW-1:0] ACC_LAST  = AW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_A_ADDR,
        S_A_ACC,
        S_A_REST
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            lat_we_q, lat_we_d;
    logic [7:0]      lat_addr_q, lat_addr_d;
    logic [7:0]      lat_wdata_q, lat_wdata_d;
    logic [7:0]      rd_buf_q, rd_buf_d;
    logic [7:0]      reg_addr_q, reg_addr_d;
    logic [7:0]      reg_wdata_q, reg_wdata_d;
    logic            reg_write_q, reg_write_d;
    logic            reg_read_q, reg_read_d;
    logic            reg_chg_q, reg_chg_d;
    logic            aux_ack_q, aux_ack_d;
    logic [7:0]      aux_rdata_q, aux_rdata_d;
    logic            aux_err_d;
    logic            cpu_active;
    logic            abort;

    assign cpu_active = cpu_read | cpu_write | cpu_regaddr_changed;

    always_comb begin
        state_d     = state_q;
        guard_d     = '0;
        acc_d       = acc_q;
        retry_d     = retry_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        rd_buf_d    = rd_buf_q;
        reg_addr_d  = cpu_addr;
        reg_wdata_d = cpu_din;
        reg_write_d = cpu_write;
        reg_read_d  = cpu_read;
        reg_chg_d   = cpu_regaddr_changed;
        aux_ack_d   = 1'b0;
        aux_err_d   = 1'b0;
        aux_rdata_d = aux_rdata_q;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_active) begin
                    guard_d = '0;
                end else if (guard_q != GUARD_MAX) begin
                    guard_d = guard_q + GW'(1);
                end else begin
                    guard_d = guard_q;
                end
                if (aux_req && !cpu_active && (guard_q >= GUARD_MAX)) begin
                    state_d     = S_A_ADDR;
                    guard_d     = '0;
                    lat_we_d    = aux_we;
                    lat_addr_d  = aux_addr;
                    lat_wdata_d = aux_wdata;
                    reg_addr_d  = aux_addr;
                    reg_wdata_d = aux_wdata;
                    reg_write_d = 1'b0;
                    reg_read_d  = 1'b0;
                    reg_chg_d   = 1'b1;
                end
            end
            S_A_ADDR: begin
                if (cpu_active) begin
                    abort = 1'b1;
                end else begin
                    state_d     = S_A_ACC;
                    acc_d       = ACC_LAST;
                    reg_addr_d  = lat_addr_q;
                    reg_wdata_d = lat_wdata_q;
                    reg_write_d = lat_we_q;
                    reg_read_d  = !lat_we_q;
                    reg_chg_d   = 1'b0;
                end
            end
            S_A_ACC: begin
                if (cpu_active) begin
                    abort = 1'b1;
                end else if (acc_q == '0) begin
                    // Consumers see the CPU address again with a change pulse so they resync.
                    state_d   = S_A_REST;
                    reg_chg_d = 1'b1;
                    if (!lat_we_q) begin
                        rd_buf_d = reg_rdata;
                    end
                end else begin
                    acc_d       = acc_q - AW'(1);
                    reg_addr_d  = lat_addr_q;
                    reg_wdata_d = lat_wdata_q;
                    reg_write_d = lat_we_q;
                    reg_read_d  = !lat_we_q;
                    reg_chg_d   = 1'b0;
                end
            end
            S_A_REST: begin
                state_d   = S_IDLE;
                aux_ack_d = 1'b1;
                retry_d   = '0;
                if (!lat_we_q) begin
                    aux_rdata_d = rd_buf_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d   = S_IDLE;
            reg_chg_d = 1'b1;
`ifdef REGARB_RETRY_LIMIT_EN
            if (retry_q == RW'(MAX_RETRIES - 1)) begin
                retry_d   = '0;
                aux_ack_d = 1'b1;
                aux_err_d = 1'b1;
            end else begin
                retry_d = retry_q + RW'(1);
            end
`else
            if (retry_q != '1) begin
                retry_d = retry_q + RW'(1);
            end
`endif
        end
    end

`ifdef REGARB_RETRY_LIMIT_EN
    logic aux_err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aux_err_q <= 1'b0;
        end else begin
            aux_err_q <= aux_err_d;
        end
    end
    assign aux_err = aux_err_q;
`else
    logic unused_err;
    assign unused_err = aux_err_d;
    assign aux_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            guard_q     <= '0;
            acc_q       <= '0;
            retry_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            reg_chg_q   <= 1'b1;
            aux_ack_q   <= 1'b0;
            aux_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            acc_q       <= acc_d;
            retry_q     <= retry_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_write_q <= reg_write_d;
            reg_read_q  <= reg_read_d;
            reg_chg_q   <= reg_chg_d;
            aux_ack_q   <= aux_ack_d;
            aux_rdata_q <= aux_rdata_d;
        end
        lat_we_q    <= lat_we_d;
        lat_addr_q  <= lat_addr_d;
        lat_wdata_q <= lat_wdata_d;
        rd_buf_q    <= rd_buf_d;
    end

    assign aux_ack             = aux_ack_q;
    assign aux_rdata           = aux_rdata_q;
    assign reg_addr            = reg_addr_q;
    assign reg_wdata           = reg_wdata_q;
    assign reg_write           = reg_write_q;
    assign reg_read            = reg_read_q;
    assign reg_regaddr_changed = reg_chg_q;

endmodule

// File: tb/tb_zxuno_regbus_arbiter.sv
// Bench for zxuno_regbus_arbiter: directed scenarios then randomized CPU/aux traffic against a
// transaction-window reference model (edge-indexed, idle-run arithmetic).
module tb_zxuno_regbus_arbiter;
    localparam int AC = 2;
    localparam int G  = 4;
    localparam int MR = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cpu_addr, cpu_din;
    logic       cpu_write, cpu_read, cpu_regaddr_changed;
    logic       aux_req, aux_we;
    logic [7:0] aux_addr, aux_wdata;
    logic       aux_ack, aux_err;
    logic [7:0] aux_rdata;
    logic [7:0] reg_addr, reg_wdata;
    logic       reg_write, reg_read, reg_regaddr_changed;
    logic [7:0] reg_rdata;
    logic [7:0] mem [256];

    always #5 clk = ~clk;
    assign reg_rdata = mem[reg_addr];

    zxuno_regbus_arbiter #(
        .ACCESS_CYCLES(AC),
        .IDLE_GUARD(G),
        .MAX_RETRIES(MR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cpu_addr(cpu_addr),
        .cpu_din(cpu_din),
        .cpu_write(cpu_write),
        .cpu_read(cpu_read),
        .cpu_regaddr_changed(cpu_regaddr_changed),
        .aux_req(aux_req),
        .aux_we(aux_we),
        .aux_addr(aux_addr),
        .aux_wdata(aux_wdata),
        .aux_ack(aux_ack),
        .aux_err(aux_err),
        .aux_rdata(aux_rdata),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_write(reg_write),
        .reg_read(reg_read),
        .reg_regaddr_changed(reg_regaddr_changed),
        .reg_rdata(reg_rdata)
    );

    int checks = 0;
    int errors = 0;
    int gap    = 0;

    // Reference model: edge counter, last edge that reset the idle run, start edge of the window.
    int         n = 0;
    int         last_busy = 0;
    int         s = 0;
    int         aborts = 0;
    bit         in_tx = 1'b0;
    logic       m_we;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] e_addr, e_wdata, e_rdata;
    logic       e_wr, e_rd, e_chg, e_ack, e_err;
    bit         e_wdata_dc;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %02h expected %02h", tag, n, got, exp);
        end
    endtask

    task automatic model_step();
        bit ca;
        int k;
        ca = cpu_read | cpu_write | cpu_regaddr_changed;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_wdata_dc = 1'b0;
        e_addr  = cpu_addr;
        e_wdata = cpu_din;
        e_wr    = cpu_write;
        e_rd    = cpu_read;
        e_chg   = cpu_regaddr_changed;
        if (!rst_n) begin
            in_tx = 1'b0;
            last_busy = n;
            aborts = 0;
            e_addr = 8'h00; e_wdata = 8'h00; e_wr = 1'b0; e_rd = 1'b0;
            e_chg = 1'b1; e_rdata = 8'h00;
        end else if (in_tx) begin
            k = n - s;
            if (ca && k <= AC + 1) begin
                e_chg = 1'b1;
                in_tx = 1'b0;
                last_busy = n;
                aborts++;
`ifdef REGARB_RETRY_LIMIT_EN
                if (aborts == MR) begin
                    e_ack = 1'b1;
                    e_err = 1'b1;
                    aborts = 0;
                end
`endif
            end else if (k <= AC) begin
                e_addr = m_addr; e_wdata = m_wdata; e_wr = m_we; e_rd = !m_we; e_chg = 1'b0;
            end else if (k == AC + 1) begin
                e_chg = 1'b1;
            end else begin
                e_ack = 1'b1;
                if (!m_we) e_rdata = mem[m_addr];
                aborts = 0;
                in_tx = 1'b0;
                last_busy = n;
            end
        end else if (aux_req && !ca && (n - last_busy > G)) begin
            in_tx = 1'b1;
            s = n;
            m_we = aux_we; m_addr = aux_addr; m_wdata = aux_wdata;
            e_addr = aux_addr; e_wr = 1'b0; e_rd = 1'b0; e_chg = 1'b1; e_wdata_dc = 1'b1;
        end else if (ca) begin
            last_busy = n;
        end
        n++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_eq("reg_addr", reg_addr, e_addr);
        if (!e_wdata_dc) check_eq("reg_wdata", reg_wdata, e_wdata);
        check_eq("reg_write", {7'b0, reg_write}, {7'b0, e_wr});
        check_eq("reg_read", {7'b0, reg_read}, {7'b0, e_rd});
        check_eq("reg_regaddr_changed", {7'b0, reg_regaddr_changed}, {7'b0, e_chg});
        check_eq("aux_ack", {7'b0, aux_ack}, {7'b0, e_ack});
        check_eq("aux_err", {7'b0, aux_err}, {7'b0, e_err});
        check_eq("aux_rdata", aux_rdata, e_rdata);
        if (e_ack) begin
            aux_req = 1'b0;
            gap = $urandom_range(0, 6);
        end
    endtask

    task automatic cpu_idle();
        cpu_write = 1'b0;
        cpu_read = 1'b0;
        cpu_regaddr_changed = 1'b0;
        cpu_addr = 8'($urandom);
        cpu_din = 8'($urandom);
    endtask

    initial begin
        int quiet;
        int busy;
        logic [2:0] p;
        quiet = 0;
        busy = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h01] = 8'h3C;

        rst_n = 1'b0;
        cpu_idle();
        aux_req = 1'b0; aux_we = 1'b0; aux_addr = 8'h00; aux_wdata = 8'h00;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        cpu_addr = 8'h0B; cpu_din = 8'h5A; cpu_write = 1'b1;
        repeat (3) tick();

        cpu_idle();
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'hC6; aux_wdata = 8'h81;
        repeat (12) tick();

        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h01;
        repeat (14) tick();

        cpu_write = 1'b1;
        tick();
        cpu_idle();
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h01;
        repeat (6) tick();
        cpu_write = 1'b1; cpu_addr = 8'h22;
        tick();
        cpu_idle();
        repeat (14) tick();

        for (int i = 0; i < 3000; i++) begin
            rst_n = !(i == 1200 || i == 1201 || i == 2300);
            if (busy > 0) begin
                p = 3'($urandom_range(1, 7));
                cpu_write = p[0];
                cpu_read = p[1];
                cpu_regaddr_changed = p[2];
                cpu_addr = 8'($urandom);
                cpu_din = 8'($urandom);
                busy--;
            end else if (quiet > 0) begin
                cpu_idle();
                quiet--;
            end else begin
                busy = $urandom_range(1, 3);
                quiet = $urandom_range(0, 14);
                cpu_idle();
            end
            if (!aux_req) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    aux_req = 1'b1;
                    aux_we = 1'($urandom_range(0, 1));
                    aux_addr = 8'($urandom);
                    aux_wdata = 8'($urandom);
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
